// File: rtl/device_bus_initiator_pkg.sv
// Shared cluster constants for the device bus: widths, well-known device
// addresses and the initiator FSM state encoding.
package cluster_defs;

  localparam int NUM_CORES         = 8;
  localparam int CORE_ID_WIDTH     = 3;
  localparam int DEVICE_ADDR_WIDTH = 10;
  localparam int DEVICE_DATA_WIDTH = 16;

  localparam logic [DEVICE_ADDR_WIDTH-1:0] DEV_ADDR_OUTPUT = 10'h3ff;
  localparam logic [DEVICE_ADDR_WIDTH-1:0] DEV_ADDR_MUTEX0 = 10'h3fe;
  localparam logic [DEVICE_ADDR_WIDTH-1:0] DEV_ADDR_MUTEX1 = 10'h3fd;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } bus_state_t;

endpackage

// File: rtl/device_bus_initiator_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins.
module rr_arbiter
  import cluster_defs::*;
(
  input  logic [NUM_CORES-1:0]     req,
  input  logic [CORE_ID_WIDTH-1:0] ptr,
  output logic [NUM_CORES-1:0]     grant,
  output logic [CORE_ID_WIDTH-1:0] grant_id,
  output logic                     valid
);

  logic [CORE_ID_WIDTH-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_id = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = ptr + CORE_ID_WIDTH'(k);
      if (req[idx]) begin
        grant_id = idx;
        valid    = 1'b1;
      end
    end
    grant = valid ? (NUM_CORES'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/device_bus_initiator.sv
// Cluster device-bus initiator: arbitrates per-core device requests and runs
// one strobe / capture / ack sequence per transaction.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | bus quiet; grant the first eligible request
// ST_STROBE  | one-cycle read or write strobe for the latched winner
// ST_CAPTURE | strobes low; responder data is sampled into core_rdata
// ST_ACK     | ack pulse to winner; re-arbitrate with the winner masked out
module device_bus_initiator
  import cluster_defs::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CORES-1:0]                      core_req,
  input  logic [NUM_CORES-1:0]                      core_we,
  input  logic [NUM_CORES*DEVICE_ADDR_WIDTH-1:0]    core_addr,
  input  logic [NUM_CORES*DEVICE_DATA_WIDTH-1:0]    core_wdata,
  output logic [NUM_CORES-1:0]                      core_ack,
  output logic [DEVICE_DATA_WIDTH-1:0]              core_rdata,
  output logic [CORE_ID_WIDTH-1:0]                  device_core_id,
  output logic                                      device_write_en,
  output logic                                      device_read_en,
  output logic [DEVICE_ADDR_WIDTH-1:0]              device_addr,
  output logic [DEVICE_DATA_WIDTH-1:0]              device_data_out,
  input  logic [DEVICE_DATA_WIDTH-1:0]              device_data_in
);

  bus_state_t               state;
  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  logic [NUM_CORES-1:0]     cur_onehot;

  logic [NUM_CORES-1:0]     arb_req;
  logic [NUM_CORES-1:0]     arb_grant;
  logic [CORE_ID_WIDTH-1:0] arb_id;
  logic                     arb_valid;

  // In ACK the winner's req is still high for this cycle and must not count.
  assign arb_req = (state == ST_ACK) ? (core_req & ~core_ack) : core_req;

  rr_arbiter u_arb (
    .req      (arb_req),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .valid    (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      cur_onehot      <= '0;
      core_ack        <= '0;
      core_rdata      <= '0;
      device_core_id  <= '0;
      device_write_en <= 1'b0;
      device_read_en  <= 1'b0;
      device_addr     <= '0;
      device_data_out <= '0;
    end else begin
      // Bus fields default to zero so the responder decode stays inert.
      core_ack        <= '0;
      device_core_id  <= '0;
      device_write_en <= 1'b0;
      device_read_en  <= 1'b0;
      device_addr     <= '0;
      device_data_out <= '0;
      case (state)
        ST_IDLE, ST_ACK: begin
          if (arb_valid) begin
            cur_onehot      <= arb_grant;
            rr_ptr          <= arb_id + 3'd1;
            device_core_id  <= arb_id;
            device_write_en <= core_we[arb_id];
            device_read_en  <= ~core_we[arb_id];
            device_addr     <= core_addr[int'(arb_id)*DEVICE_ADDR_WIDTH +: DEVICE_ADDR_WIDTH];
            device_data_out <= core_wdata[int'(arb_id)*DEVICE_DATA_WIDTH +: DEVICE_DATA_WIDTH];
            state           <= ST_STROBE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_STROBE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          core_ack   <= cur_onehot;
          core_rdata <= device_data_in;
          state      <= ST_ACK;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_device_bus_initiator.sv
// Scoreboard bench for device_bus_initiator: requests are queued per core at
// issue time, a monitor checks strobes, round-robin order, acks and read data.
module tb_device_bus_initiator;
  import cluster_defs::*;

  localparam int NC = 8;

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   core_req = '0;
  logic [7:0]   core_we = '0;
  logic [79:0]  core_addr = '0;
  logic [127:0] core_wdata = '0;
  logic [7:0]   core_ack;
  logic [15:0]  core_rdata;
  logic [2:0]   device_core_id;
  logic         device_write_en;
  logic         device_read_en;
  logic [9:0]   device_addr;
  logic [15:0]  device_data_out;
  logic [15:0]  device_data_in = '0;

  device_bus_initiator dut (
    .clk             (clk),
    .reset           (reset),
    .core_req        (core_req),
    .core_we         (core_we),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_ack        (core_ack),
    .core_rdata      (core_rdata),
    .device_core_id  (device_core_id),
    .device_write_en (device_write_en),
    .device_read_en  (device_read_en),
    .device_addr     (device_addr),
    .device_data_out (device_data_out),
    .device_data_in  (device_data_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Registered responder (bus side) and the bench's own view of device memory.
  logic [15:0] dev_mem [1024];
  logic [15:0] ref_mem [1024];

  always @(posedge clk) begin
    if (device_read_en)  device_data_in <= dev_mem[device_addr];
    if (device_write_en) dev_mem[device_addr] <= device_data_out;
  end

  txn_t exp_q [NC][$];
  int   strobe_log [$];
  bit   ack_done [NC];
  bit   persist [NC];
  bit   rst_edge = 1'b0;

  // Reference model state: owner of the in-flight transaction and the RR pointer.
  int          cyc = 0;
  bit          pending = 1'b0;
  int          pid = 0;
  int          s_cyc = 0;
  logic        pwe = 1'b0;
  logic [15:0] exp_rdata = '0;
  logic [15:0] held_rdata = '0;
  logic [7:0]  snap = '0;
  int          ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic new_req(input int i, input logic we, input logic [9:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    core_we[i] = we;
    core_addr[i*10 +: 10] = a;
    core_wdata[i*16 +: 16] = d;
    core_req[i] = 1'b1;
    exp_q[i].push_back(t);
  endtask

  task automatic rand_req(input int i);
    new_req(i, 1'($urandom), 10'h3f0 + 10'($urandom_range(0, 15)), 16'($urandom));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NC; i++) if (exp_q[i].size() != 0) return 1'b0;
    return core_req == 8'h00;
  endfunction

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(posedge clk);
      ok = all_empty();
    end
    check({name, "_drain"}, 64'(ok), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    rst_edge = reset;
  end

  // Core-side behaviour after an ack: drop req, or re-request at once.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (ack_done[i]) begin
        ack_done[i] = 1'b0;
        if (persist[i]) rand_req(i);
        else core_req[i] = 1'b0;
      end
    end
  end

  logic [7:0] m_exp_ack;
  bit         m_strobe;
  bit         m_exp_s;
  int         m_eid;
  txn_t       m_t;

  initial forever begin
    @(negedge clk);
    cyc++;
    m_exp_ack = '0;
    if (!rst_edge) begin
      check("reset_core", {core_ack, core_rdata}, 64'd0);
      check("reset_bus", {device_core_id, device_write_en, device_read_en, device_addr, device_data_out}, 64'd0);
      pending = 1'b0;
      ptr = 0;
      held_rdata = '0;
    end else begin
      m_strobe = device_read_en | device_write_en;
      m_exp_s = (snap != 8'h00) && !pending;
      check("strobe_present", 64'(m_strobe), 64'(m_exp_s));
      if (m_strobe) begin
        check("one_strobe", 64'(device_read_en & device_write_en), 64'd0);
        m_eid = -1;
        for (int k = 0; k < NC; k++)
          if (m_eid < 0 && snap[(ptr + k) % NC]) m_eid = (ptr + k) % NC;
        check("rr_winner", 64'(device_core_id), 64'(m_eid));
        strobe_log.push_back(int'(device_core_id));
        if (exp_q[device_core_id].size() == 0) begin
          check("strobe_has_req", 64'd0, 64'd1);
          pwe = 1'b1;
        end else begin
          m_t = exp_q[device_core_id][0];
          check("strobe_we", 64'(device_write_en), 64'(m_t.we));
          check("strobe_addr", 64'(device_addr), 64'(m_t.addr));
          if (m_t.we) begin
            check("strobe_wdata", 64'(device_data_out), 64'(m_t.wdata));
            ref_mem[m_t.addr] = m_t.wdata;
          end else begin
            exp_rdata = ref_mem[m_t.addr];
          end
          pwe = m_t.we;
        end
        pending = 1'b1;
        pid = int'(device_core_id);
        s_cyc = cyc;
        ptr = (int'(device_core_id) + 1) % NC;
      end else begin
        check("idle_bus", {device_core_id, device_addr, device_data_out}, 64'd0);
      end
      if (pending && cyc == s_cyc + 2) m_exp_ack = 8'(1) << pid;
      check("ack", 64'(core_ack), 64'(m_exp_ack));
      if (m_exp_ack != 8'h00) begin
        if (!pwe) begin
          check("rdata", 64'(core_rdata), 64'(exp_rdata));
          held_rdata = exp_rdata;
        end else begin
          held_rdata = core_rdata;
        end
        if (exp_q[pid].size() > 0) void'(exp_q[pid].pop_front());
        ack_done[pid] = 1'b1;
        pending = 1'b0;
      end else begin
        check("rdata_hold", 64'(core_rdata), 64'(held_rdata));
      end
    end
    snap = core_req & ~m_exp_ack;
  end

  initial begin
    bit found;
    for (int a = 0; a < 1024; a++) begin
      dev_mem[a] = (a == 10'h3fe) ? 16'h0001 : 16'(a * 37 + 5);
      ref_mem[a] = (a == 10'h3fe) ? 16'h0001 : 16'(a * 37 + 5);
    end
    for (int i = 0; i < NC; i++) begin
      ack_done[i] = 1'b0;
      persist[i] = 1'b0;
    end

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Quiet bus for 20 cycles.
    repeat (20) @(posedge clk);

    // Cores 1 and 6 together after reset; core 1 re-requests immediately.
    #1;
    strobe_log.delete();
    persist[1] = 1'b1;
    new_req(1, 1'b0, 10'h3f1, 16'h0);
    new_req(6, 1'b1, 10'h3f6, 16'hbeef);
    for (int c = 0; c < 60 && strobe_log.size() < 3; c++) @(posedge clk);
    persist[1] = 1'b0;
    check("order_count", 64'(strobe_log.size() >= 3), 64'd1);
    if (strobe_log.size() >= 3) begin
      check("order_0", 64'(strobe_log[0]), 64'd1);
      check("order_1", 64'(strobe_log[1]), 64'd6);
      check("order_2", 64'(strobe_log[2]), 64'd1);
    end
    wait_drain("pair");

    // Core 2 writes the console address.
    #1 new_req(2, 1'b1, 10'h3ff, 16'h1234);
    wait_drain("write");

    // Core 5 reads mutex 0; responder returns 0x0001.
    #1 new_req(5, 1'b0, 10'h3fe, 16'h0);
    wait_drain("read");

    // Reset while core 3's strobe is on the bus.
    #1 new_req(3, 1'b0, 10'h3fd, 16'h0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = (device_read_en || device_write_en) && device_core_id == 3'd3;
    end
    check("core3_strobe_seen", 64'(found), 64'd1);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_drain("after_reset");

    // All eight cores hold requests continuously.
    #1;
    strobe_log.delete();
    for (int i = 0; i < NC; i++) begin
      persist[i] = 1'b1;
      rand_req(i);
    end
    for (int c = 0; c < 120 && strobe_log.size() < 17; c++) @(posedge clk);
    for (int i = 0; i < NC; i++) persist[i] = 1'b0;
    check("all8_count", 64'(strobe_log.size() >= 17), 64'd1);
    if (strobe_log.size() >= 17)
      for (int k = 1; k < 17; k++)
        check("all8_rotate", 64'(strobe_log[k]), 64'((strobe_log[k-1] + 1) % NC));
    wait_drain("all8");

    // Randomised traffic.
    for (int i = 0; i < NC; i++) persist[i] = 1'($urandom_range(0, 3) == 0);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++)
        if (!core_req[i] && !ack_done[i] && $urandom_range(0, 3) == 0) rand_req(i);
    end
    for (int i = 0; i < NC; i++) persist[i] = 1'b0;
    wait_drain("random");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
